// File: rtl/pwm_sample_fifo.sv
// Sample FIFO feeding the PWM threshold register.
// A reloadable timer paces pops; RATE==0 writes samples straight through.
module pwm_sample_fifo #(
  parameter int PWMBITS  = 8,
  parameter int DEPTH    = 4,
  parameter int RATEBITS = 10
) (
  input  logic                     CLK,
  input  logic                     nRESET,
  input  logic                     WR,
  input  logic [PWMBITS-1:0]       WDATA,
  input  logic [RATEBITS-1:0]      RATE,
  input  logic                     FLUSH,
  output logic [PWMBITS-1:0]       PWMD,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     UNDERRUN,
  output logic                     OVERRUN,
  output logic                     TICK
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [RATEBITS-1:0] cnt_q, cnt_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [PWMBITS-1:0]  pwmd_q, pwmd_d;
  logic                und_q, und_d;
  logic                ovr_q, ovr_d;
  logic [PWMBITS-1:0]  mem_q [DEPTH];

  logic bypass;
  logic tick;
  logic full;
  logic empty;
  logic pop;
  logic push;

  assign bypass = (RATE == '0);
  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  // Gated by reset so TICK reads 0 while held in reset.
  assign tick   = nRESET && !bypass
                  && (cnt_q == '0);

  always_comb begin
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    pwmd_d  = pwmd_q;
    und_d   = und_q;
    ovr_d   = ovr_q;
    pop     = 1'b0;
    push    = 1'b0;
    if (FLUSH) begin
      cnt_d   = RATE;
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      und_d   = 1'b0;
      ovr_d   = 1'b0;
    end else if (bypass) begin
      if (cnt_q != '0)
        cnt_d = cnt_q - RATEBITS'(1);
      if (WR)
        pwmd_d = WDATA;
    end else begin
      cnt_d = tick ? RATE
                   : cnt_q - RATEBITS'(1);
      pop   = tick && !empty;
      push  = WR && (!full || pop);
      if (tick && empty)
        und_d = 1'b1;
      if (WR && full && !pop)
        ovr_d = 1'b1;
      if (pop) begin
        pwmd_d = mem_q[rptr_q];
        rptr_d = rptr_q + AW'(1);
      end
      if (push)
        wptr_d = wptr_q + AW'(1);
      if (push && !pop)
        level_d = level_q + LW'(1);
      else if (pop && !push)
        level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      pwmd_q  <= '0;
      und_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      pwmd_q  <= pwmd_d;
      und_q   <= und_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= WDATA;
    end
  end

  assign PWMD     = pwmd_q;
  assign LEVEL    = level_q;
  assign FULL     = full;
  assign EMPTY    = empty;
  assign UNDERRUN = und_q;
  assign OVERRUN  = ovr_q;
  assign TICK     = tick;

endmodule

// File: tb/tb_pwm_sample_fifo.sv
// Randomized + directed bench for pwm_sample_fifo.
// Queue-based reference model checked on every falling edge.
module tb_pwm_sample_fifo;

  localparam int PW    = 8;
  localparam int DEPTH = 4;
  localparam int RB    = 10;

  logic          CLK    = 1'b0;
  logic          nRESET = 1'b0;
  logic          WR     = 1'b0;
  logic          FLUSH  = 1'b0;
  logic [PW-1:0] WDATA  = '0;
  logic [RB-1:0] RATE   = 10'd3;

  logic [PW-1:0] PWMD;
  logic [2:0]    LEVEL;
  logic          FULL, EMPTY;
  logic          UNDERRUN, OVERRUN, TICK;

  int total = 0;
  int bad   = 0;

  pwm_sample_fifo #(
    .PWMBITS (PW),
    .DEPTH   (DEPTH),
    .RATEBITS(RB)
  ) dut (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .WR      (WR),
    .WDATA   (WDATA),
    .RATE    (RATE),
    .FLUSH   (FLUSH),
    .PWMD    (PWMD),
    .LEVEL   (LEVEL),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .UNDERRUN(UNDERRUN),
    .OVERRUN (OVERRUN),
    .TICK    (TICK)
  );

  always #5 CLK = ~CLK;

  // Reference model: a queue of pending samples plus
  // the number of cycles left before the next tick.
  int            m_cnt  = 0;
  logic [PW-1:0] m_pwmd = '0;
  bit            m_und  = 1'b0;
  bit            m_ovr  = 1'b0;
  logic [PW-1:0] q[$];

  initial begin
    forever begin
      @(posedge CLK or negedge nRESET);
      if (!nRESET) begin
        q.delete();
        m_cnt  = 0;
        m_pwmd = '0;
        m_und  = 1'b0;
        m_ovr  = 1'b0;
      end else if (FLUSH) begin
        q.delete();
        m_cnt = int'(RATE);
        m_und = 1'b0;
        m_ovr = 1'b0;
      end else if (RATE == 0) begin
        if (WR) m_pwmd = WDATA;
        if (m_cnt > 0) m_cnt--;
      end else begin
        bit t;
        t = (m_cnt == 0);
        m_cnt = t ? int'(RATE) : m_cnt - 1;
        if (t) begin
          if (q.size() > 0) m_pwmd = q.pop_front();
          else m_und = 1'b1;
        end
        if (WR) begin
          if (q.size() < DEPTH) q.push_back(WDATA);
          else m_ovr = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      bit et;
      @(negedge CLK);
      et = nRESET && (m_cnt == 0) && (RATE != 0);
      chk("m_pwmd",  PWMD,     m_pwmd);
      chk("m_level", LEVEL,    q.size());
      chk("m_full",  FULL,     q.size() == DEPTH);
      chk("m_empty", EMPTY,    q.size() == 0);
      chk("m_und",   UNDERRUN, m_und);
      chk("m_ovr",   OVERRUN,  m_ovr);
      chk("m_tick",  TICK,     et);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_tick(input int budget);
    int n = 0;
    while (!TICK && n < budget) begin
      cyc();
      n++;
    end
    chk("tick_wait", TICK, 1);
  endtask

  task automatic rst_vals(input string nm);
    chk({nm, "_pwmd"},  PWMD, 0);
    chk({nm, "_level"}, LEVEL, 0);
    chk({nm, "_empty"}, EMPTY, 1);
    chk({nm, "_full"},  FULL, 0);
    chk({nm, "_und"},   UNDERRUN, 0);
    chk({nm, "_ovr"},   OVERRUN, 0);
    chk({nm, "_tick"},  TICK, 0);
  endtask

  initial begin
    logic [PW-1:0] exp3 [3];
    int n;
    exp3[0] = 8'h10;
    exp3[1] = 8'h20;
    exp3[2] = 8'h30;

    // Reset values, then first tick right after release
    repeat (3) cyc();
    rst_vals("reset");
    nRESET = 1'b1;
    #1;
    chk("first_tick", TICK, 1);
    cyc();
    chk("first_und", UNDERRUN, 1);

    // Period check, RATE=3
    FLUSH = 1'b1; cyc(); FLUSH = 1'b0;
    chk("flush_und", UNDERRUN, 0);
    WR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      WDATA = exp3[i];
      cyc();
    end
    WR = 1'b0;
    chk("per_level3", LEVEL, 3);
    chk("per_tick", TICK, 1);
    cyc();
    chk("per_pwmd0", PWMD, exp3[0]);
    chk("per_lvl0", LEVEL, 2);
    for (int k = 1; k < 3; k++) begin
      repeat (4) cyc();
      chk("per_pwmd", PWMD, exp3[k]);
      chk("per_lvl", LEVEL, 2 - k);
    end
    chk("per_und", UNDERRUN, 0);
    chk("per_ovr", OVERRUN, 0);

    // Overflow, RATE=1023
    RATE = 10'd1023;
    FLUSH = 1'b1; cyc(); FLUSH = 1'b0;
    WR = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      WDATA = PW'(i);
      cyc();
      if (i == 4) chk("ovf_full", FULL, 1);
      if (i == 4) chk("ovf_ovr4", OVERRUN, 0);
    end
    WR = 1'b0;
    chk("ovf_ovr", OVERRUN, 1);
    chk("ovf_lvl", LEVEL, 4);
    for (int k = 1; k <= 4; k++) begin
      wait_tick(1100);
      cyc();
      chk("ovf_pop", PWMD, k);
    end

    // Full with a simultaneous pop, RATE=7
    RATE = 10'd7;
    FLUSH = 1'b1; cyc(); FLUSH = 1'b0;
    WR = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      WDATA = 8'hA0 + PW'(i);
      cyc();
    end
    WR = 1'b0;
    chk("fp_full", FULL, 1);
    repeat (3) cyc();
    chk("fp_tick", TICK, 1);
    WR = 1'b1; WDATA = 8'hA5;
    cyc();
    WR = 1'b0;
    chk("fp_lvl", LEVEL, 4);
    chk("fp_ovr", OVERRUN, 0);
    chk("fp_pwmd", PWMD, 8'hA1);
    for (int k = 2; k <= 5; k++) begin
      repeat (8) cyc();
      chk("fp_pop", PWMD, 8'hA0 + k);
    end

    // Underrun, RATE=2, PWMD preloaded via bypass
    RATE = 10'd0;
    WR = 1'b1; WDATA = 8'h80;
    cyc();
    WR = 1'b0;
    chk("byp_80", PWMD, 8'h80);
    RATE = 10'd2;
    FLUSH = 1'b1; cyc(); FLUSH = 1'b0;
    repeat (3) cyc();
    chk("und_set", UNDERRUN, 1);
    chk("und_hold", PWMD, 8'h80);
    repeat (2) cyc();
    chk("und_tick", TICK, 1);
    WR = 1'b1; WDATA = 8'h55;
    cyc();
    WR = 1'b0;
    chk("und_lvl", LEVEL, 1);
    chk("und_pwmd", PWMD, 8'h80);
    repeat (3) cyc();
    chk("und_55", PWMD, 8'h55);

    // Bypass then flush
    RATE = 10'd0;
    WR = 1'b1; WDATA = 8'hAB;
    cyc();
    WR = 1'b0;
    chk("byp_ab", PWMD, 8'hAB);
    repeat (3) cyc();
    chk("byp_notick", TICK, 0);
    RATE = 10'd5;
    #1;
    chk("r5_tick", TICK, 1);
    cyc();
    WR = 1'b1;
    WDATA = 8'h01; cyc();
    WDATA = 8'h02; cyc();
    WR = 1'b0;
    chk("r5_lvl", LEVEL, 2);
    chk("r5_und", UNDERRUN, 1);
    FLUSH = 1'b1; cyc(); FLUSH = 1'b0;
    chk("fl_lvl", LEVEL, 0);
    chk("fl_und", UNDERRUN, 0);
    chk("fl_pwmd", PWMD, 8'hAB);
    n = 0;
    while (!TICK && n < 20) begin
      cyc();
      n++;
    end
    chk("fl_period", n, 5);

    // Asynchronous reset between edges
    RATE = 10'd7;
    FLUSH = 1'b1; cyc(); FLUSH = 1'b0;
    WR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      WDATA = PW'(8'hC0 + i);
      cyc();
    end
    WR = 1'b0;
    chk("ar_lvl3", LEVEL, 3);
    #1;
    nRESET = 1'b0;
    #1;
    rst_vals("async");
    cyc();
    cyc();
    nRESET = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      WR    = 1'($urandom_range(0, 1));
      WDATA = PW'($urandom);
      FLUSH = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 4))
          0: RATE = 10'd0;
          1: RATE = 10'd1;
          2: RATE = 10'd2;
          3: RATE = 10'd3;
          default: RATE = RB'($urandom_range(4, 12));
        endcase
      end
      if ($urandom_range(0, 999) == 0) begin
        nRESET = 1'b0;
        cyc();
        cyc();
        nRESET = 1'b1;
      end
      cyc();
    end
    WR = 1'b0;
    FLUSH = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
